// File: rtl/avalon_sram_test_master.sv
// Hardware Avalon-MM master that programs the SRAM controller register file,
// kicks a run, polls status until done or timeout, and reports the results.
module avalon_sram_test_master #(
   parameter int DONE_BIT      = 0,
   parameter int POLL_GAP      = 4,
   parameter int TIMEOUT_POLLS = 1024,
   parameter int CNT_W         = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [31:0] cfg_sta_addr,
   input  logic [31:0] cfg_area,
   input  logic [31:0] cfg_op,
   output logic        chipselect,
   output logic [2:0]  address,
   output logic        write,
   output logic [31:0] writedata,
   output logic        read,
   input  logic [31:0] readdata,
   output logic        busy,
   output logic        done,
   output logic        err_timeout,
   output logic [31:0] res_addr,
   output logic [31:0] res_data,
   output logic [31:0] res_status
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_W0    = 4'd1;
   localparam logic [3:0] S_W1    = 4'd2;
   localparam logic [3:0] S_W2    = 4'd3;
   localparam logic [3:0] S_WEN   = 4'd4;
   localparam logic [3:0] S_WSND  = 4'd5;
   localparam logic [3:0] S_WSNDC = 4'd6;
   localparam logic [3:0] S_POLL  = 4'd7;
   localparam logic [3:0] S_GAP   = 4'd8;
   localparam logic [3:0] S_R5    = 4'd9;
   localparam logic [3:0] S_R6    = 4'd10;
   localparam logic [3:0] S_WENC  = 4'd11;
   localparam logic [3:0] S_FIN   = 4'd12;

   localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_POLLS);
   localparam logic [CNT_W-1:0] GAP_LAST = (POLL_GAP > 0) ? CNT_W'(POLL_GAP - 1) : '0;

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d, poll_inc;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [31:0]      sta_q, sta_d, area_q, area_d, op_q, op_d;
   logic             tmo_q, tmo_d;
   logic [31:0]      res_addr_q, res_addr_d, res_data_q, res_data_d;
   logic [31:0]      res_status_q, res_status_d;
   logic             err_timeout_q, err_timeout_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             cs_q, cs_d, wr_q, wr_d, rd_q, rd_d;
   logic [2:0]       addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;

   always_comb begin
      state_d       = state_q;
      poll_cnt_d    = poll_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      sta_d         = sta_q;
      area_d        = area_q;
      op_d          = op_q;
      tmo_d         = tmo_q;
      res_addr_d    = res_addr_q;
      res_data_d    = res_data_q;
      res_status_d  = res_status_q;
      err_timeout_d = err_timeout_q;
      poll_inc      = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + CNT_W'(1);

      case (state_q)
         S_IDLE: if (start) begin
            state_d       = S_W0;
            sta_d         = cfg_sta_addr;
            area_d        = cfg_area;
            op_d          = cfg_op;
            tmo_d         = 1'b0;
            res_addr_d    = '0;
            res_data_d    = '0;
            res_status_d  = '0;
            err_timeout_d = 1'b0;
            poll_cnt_d    = '0;
            gap_cnt_d     = '0;
         end
         S_W0:    state_d = S_W1;
         S_W1:    state_d = S_W2;
         S_W2:    state_d = S_WEN;
         S_WEN:   state_d = S_WSND;
         S_WSND:  state_d = S_WSNDC;
         S_WSNDC: state_d = S_POLL;
         S_POLL: begin
            res_status_d = readdata;
            poll_cnt_d   = poll_inc;
            gap_cnt_d    = '0;
            if (readdata[DONE_BIT])        state_d = S_R5;
            else if (poll_inc >= TMO_LIM) begin
               tmo_d   = 1'b1;
               state_d = S_WENC;
            end
            else if (POLL_GAP == 0)        state_d = S_POLL;
            else                           state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_cnt_q >= GAP_LAST) state_d = S_POLL;
            else                       gap_cnt_d = gap_cnt_q + CNT_W'(1);
         end
         S_R5: begin
            res_addr_d = readdata;
            state_d    = S_R6;
         end
         S_R6: begin
            res_data_d = readdata;
            state_d    = S_WENC;
         end
         S_WENC: begin
            err_timeout_d = tmo_q;  // surfaces together with done
            state_d       = S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bus strobes are decoded from the next state so they come straight off flops.
   always_comb begin
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      addr_d  = 3'd0;
      wdata_d = 32'd0;
      case (state_d)
         S_W0:    begin wr_d = 1'b1; addr_d = 3'd0; wdata_d = sta_d;  end
         S_W1:    begin wr_d = 1'b1; addr_d = 3'd1; wdata_d = area_d; end
         S_W2:    begin wr_d = 1'b1; addr_d = 3'd2; wdata_d = op_d;   end
         S_WEN:   begin wr_d = 1'b1; addr_d = 3'd4; wdata_d = 32'd1;  end
         S_WSND:  begin wr_d = 1'b1; addr_d = 3'd3; wdata_d = 32'd1;  end
         S_WSNDC: begin wr_d = 1'b1; addr_d = 3'd3; wdata_d = 32'd0;  end
         S_POLL:  begin rd_d = 1'b1; addr_d = 3'd7; end
         S_R5:    begin rd_d = 1'b1; addr_d = 3'd5; end
         S_R6:    begin rd_d = 1'b1; addr_d = 3'd6; end
         S_WENC:  begin wr_d = 1'b1; addr_d = 3'd4; wdata_d = 32'd0;  end
         default: ;
      endcase
      cs_d   = wr_d | rd_d;
      busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
      done_d = (state_d == S_FIN);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         poll_cnt_q    <= '0;
         gap_cnt_q     <= '0;
         sta_q         <= '0;
         area_q        <= '0;
         op_q          <= '0;
         tmo_q         <= 1'b0;
         res_addr_q    <= '0;
         res_data_q    <= '0;
         res_status_q  <= '0;
         err_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         cs_q          <= 1'b0;
         wr_q          <= 1'b0;
         rd_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
      end else begin
         state_q       <= state_d;
         poll_cnt_q    <= poll_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         sta_q         <= sta_d;
         area_q        <= area_d;
         op_q          <= op_d;
         tmo_q         <= tmo_d;
         res_addr_q    <= res_addr_d;
         res_data_q    <= res_data_d;
         res_status_q  <= res_status_d;
         err_timeout_q <= err_timeout_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         cs_q          <= cs_d;
         wr_q          <= wr_d;
         rd_q          <= rd_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
      end
   end

   assign chipselect  = cs_q;
   assign write       = wr_q;
   assign read        = rd_q;
   assign address     = addr_q;
   assign writedata   = wdata_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_timeout = err_timeout_q;
   assign res_addr    = res_addr_q;
   assign res_data    = res_data_q;
   assign res_status  = res_status_q;

endmodule

// File: tb/tb_avalon_sram_test_master.sv
// Bench: three masters with different parameters against a register-file slave
// model; a transaction-level model predicts every bus cycle and result value.
`timescale 1ns/1ps
module tb_avalon_sram_test_master;

   localparam int NI = 3;
   localparam int DB [NI] = '{0, 0, 3};
   localparam int PG [NI] = '{4, 0, 1};
   localparam int TP [NI] = '{4, 4, 8};

   typedef struct {
      logic        cs, rd, wr;
      logic [2:0]  addr;
      logic [31:0] wd;
      logic        busy, done;
      logic [31:0] ra, rdd, rs;
      logic        err, chk_err;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   logic [NI-1:0] start, cs, wr, rd, busy, done, err;
   logic [31:0] sta, area, op;
   logic [2:0]  addr [NI];
   logic [31:0] wd [NI], rdata [NI], ra [NI], rdd [NI], rs [NI];

   int          done_at [NI];
   logic [31:0] nd_val [NI], dn_val [NI], r5 [NI], r6 [NI];
   int          sl_n [NI];

   exp_t        q [NI][$];
   logic [31:0] h_ra [NI], h_rd [NI], h_rs [NI];
   logic        h_err [NI];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NI; k++) begin : g_dut
      avalon_sram_test_master #(
         .DONE_BIT(DB[k]), .POLL_GAP(PG[k]), .TIMEOUT_POLLS(TP[k]), .CNT_W(16)
      ) u_dut (
         .clk(clk), .reset_n(reset_n), .start(start[k]),
         .cfg_sta_addr(sta), .cfg_area(area), .cfg_op(op),
         .chipselect(cs[k]), .address(addr[k]), .write(wr[k]), .writedata(wd[k]),
         .read(rd[k]), .readdata(rdata[k]),
         .busy(busy[k]), .done(done[k]), .err_timeout(err[k]),
         .res_addr(ra[k]), .res_data(rdd[k]), .res_status(rs[k])
      );
      // slave: status turns "done" from the done_at-th poll read after the kick
      assign rdata[k] = (rd[k] && cs[k]) ?
                        ((addr[k] == 3'd7) ? (((sl_n[k] + 1) >= done_at[k]) ? dn_val[k] : nd_val[k]) :
                         (addr[k] == 3'd5) ? r5[k] :
                         (addr[k] == 3'd6) ? r6[k] : 32'h0) : 32'h0;
   end

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NI; k++) sl_n[k] <= 0;
      end else begin
         for (int k = 0; k < NI; k++) begin
            if (cs[k] && wr[k] && addr[k] == 3'd3 && wd[k] == 32'd1) sl_n[k] <= 0;
            else if (cs[k] && rd[k] && addr[k] == 3'd7)               sl_n[k] <= sl_n[k] + 1;
         end
      end
   end

   function automatic void add(int k, logic w, logic r, logic [2:0] a, logic [31:0] d,
                               logic bz, logic dn, logic [31:0] xa, logic [31:0] xd,
                               logic [31:0] xs, logic xe);
      exp_t e;
      e.cs = w | r; e.wr = w; e.rd = r; e.addr = a; e.wd = d;
      e.busy = bz; e.done = dn; e.ra = xa; e.rdd = xd; e.rs = xs;
      e.err = xe; e.chk_err = !bz;
      q[k].push_back(e);
   endfunction

   // Expected trace of a whole run, one entry per cycle starting at W0.
   function automatic void build(int k);
      logic [31:0] ca, cd, cst, s;
      logic tmo;
      ca = 0; cd = 0; cst = 0; tmo = 1'b0;
      add(k, 1, 0, 3'd0, sta,   1, 0, ca, cd, cst, 0);
      add(k, 1, 0, 3'd1, area,  1, 0, ca, cd, cst, 0);
      add(k, 1, 0, 3'd2, op,    1, 0, ca, cd, cst, 0);
      add(k, 1, 0, 3'd4, 32'd1, 1, 0, ca, cd, cst, 0);
      add(k, 1, 0, 3'd3, 32'd1, 1, 0, ca, cd, cst, 0);
      add(k, 1, 0, 3'd3, 32'd0, 1, 0, ca, cd, cst, 0);
      for (int p = 1; p <= TP[k]; p++) begin
         s = (p >= done_at[k]) ? dn_val[k] : nd_val[k];
         add(k, 0, 1, 3'd7, 32'd0, 1, 0, ca, cd, cst, 0);
         cst = s;
         if (s[DB[k]]) begin
            add(k, 0, 1, 3'd5, 32'd0, 1, 0, ca, cd, cst, 0);
            ca = r5[k];
            add(k, 0, 1, 3'd6, 32'd0, 1, 0, ca, cd, cst, 0);
            cd = r6[k];
            break;
         end
         if (p == TP[k]) begin
            tmo = 1'b1;
            break;
         end
         for (int g = 0; g < PG[k]; g++) add(k, 0, 0, 3'd0, 32'd0, 1, 0, ca, cd, cst, 0);
      end
      add(k, 1, 0, 3'd4, 32'd0, 1, 0, ca, cd, cst, 0);
      add(k, 0, 0, 3'd0, 32'd0, 0, 1, ca, cd, cst, tmo);
      h_ra[k] = ca; h_rd[k] = cd; h_rs[k] = cst; h_err[k] = tmo;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         exp_t e;
         logic idle;
         idle = 1'b0;
         if (!reset_n) begin
            q[k].delete();
            h_ra[k] = 0; h_rd[k] = 0; h_rs[k] = 0; h_err[k] = 0;
         end else begin
            idle = (q[k].size() == 0);
         end
         if (idle || !reset_n) begin
            e.cs = 0; e.rd = 0; e.wr = 0; e.addr = 0; e.wd = 0; e.busy = 0; e.done = 0;
            e.ra = h_ra[k]; e.rdd = h_rd[k]; e.rs = h_rs[k]; e.err = h_err[k]; e.chk_err = 1;
         end else begin
            e = q[k].pop_front();
         end
         n_cmp++;
         if ({cs[k], rd[k], wr[k], addr[k], wd[k], busy[k], done[k]} !==
             {e.cs, e.rd, e.wr, e.addr, e.wd, e.busy, e.done}) begin
            n_err++;
            $display("FAIL bus[%0d] t=%0t got cs%b rd%b wr%b a%0d wd=%h busy%b done%b want cs%b rd%b wr%b a%0d wd=%h busy%b done%b",
                     k, $time, cs[k], rd[k], wr[k], addr[k], wd[k], busy[k], done[k],
                     e.cs, e.rd, e.wr, e.addr, e.wd, e.busy, e.done);
         end
         n_cmp++;
         if ({ra[k], rdd[k], rs[k]} !== {e.ra, e.rdd, e.rs}) begin
            n_err++;
            $display("FAIL res[%0d] t=%0t got %h/%h/%h want %h/%h/%h",
                     k, $time, ra[k], rdd[k], rs[k], e.ra, e.rdd, e.rs);
         end
         if (e.chk_err) begin
            n_cmp++;
            if (err[k] !== e.err) begin
               n_err++;
               $display("FAIL err_timeout[%0d] t=%0t got %b want %b", k, $time, err[k], e.err);
            end
         end
         if (reset_n && idle && start[k]) build(k);
      end
   end

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h want %h", nm, got, exp);
      end
   endtask

   task automatic kick(int k, logic [31:0] a, logic [31:0] b, logic [31:0] c);
      sta = a; area = b; op = c; start[k] = 1'b1;
      @(posedge clk); #1;
      start[k] = 1'b0;
      sta = 32'hDEAD_0000; area = 32'hDEAD_0001; op = 32'hDEAD_0002;
   endtask

   // Called one cycle into a run; returns the cycle index (W0 = 1) of done.
   task automatic wait_done(int k, int budget, output int cyc);
      cyc = 1;
      while (!done[k] && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("done_seen", {31'd0, done[k]}, 32'd1);
   endtask

   task automatic wait_poll(int k);
      int w;
      w = 0;
      while (!(rd[k] && addr[k] == 3'd7) && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk("poll_reached", {31'd0, rd[k] && addr[k] == 3'd7}, 32'd1);
   endtask

   initial begin
      int cyc;
      reset_n = 1'b1;
      start = '0; sta = 0; area = 0; op = 0;
      for (int k = 0; k < NI; k++) begin
         done_at[k] = 1000; nd_val[k] = 0; dn_val[k] = 1; r5[k] = 0; r6[k] = 0;
      end
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs",   {29'd0, cs},   32'd0);
      chk("rst_busy", {29'd0, busy}, 32'd0);
      chk("rst_done", {29'd0, done}, 32'd0);
      chk("rst_addr", {29'd0, addr[0]}, 32'd0);
      chk("rst_res",  ra[0] | rdd[0] | rs[0], 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // reset while the first status read is on the bus
      kick(0, 32'h11, 32'h22, 32'h33);
      wait_poll(0);
      reset_n = 1'b0;
      #1;
      chk("rstmid_read", {31'd0, rd[0]},   32'd0);
      chk("rstmid_cs",   {31'd0, cs[0]},   32'd0);
      chk("rstmid_busy", {31'd0, busy[0]}, 32'd0);
      chk("rstmid_done", {31'd0, done[0]}, 32'd0);
      chk("rstmid_err",  {31'd0, err[0]},  32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      // nominal: done on the third poll
      done_at[0] = 3; r5[0] = 32'h3FF; r6[0] = 32'hA5;
      kick(0, 32'h10, 32'h20, 32'h3);
      wait_done(0, 100, cyc);
      chk("nom_len", cyc, 32'd21);
      @(posedge clk); #1;
      chk("nom_res_addr",   ra[0],  32'h3FF);
      chk("nom_res_data",   rdd[0], 32'hA5);
      chk("nom_res_status", rs[0],  32'h1);
      chk("nom_err",        {31'd0, err[0]}, 32'd0);
      chk("nom_polls",      sl_n[0], 32'd3);

      // immediate done, back-to-back polling instance
      done_at[1] = 1; r5[1] = 32'h1234; r6[1] = 32'h5678;
      kick(1, 32'hA, 32'hB, 32'hC);
      wait_done(1, 100, cyc);
      chk("imm_len", cyc, 32'd11);
      @(posedge clk); #1;
      chk("imm_res_addr", ra[1], 32'h1234);
      chk("imm_polls",    sl_n[1], 32'd1);

      // timeout after four polls
      done_at[0] = 1000;
      kick(0, 32'h40, 32'h50, 32'h60);
      wait_done(0, 100, cyc);
      chk("tmo_len", cyc, 32'd24);
      chk("tmo_err_at_done", {31'd0, err[0]}, 32'd1);
      @(posedge clk); #1;
      chk("tmo_res_addr", ra[0],  32'd0);
      chk("tmo_res_data", rdd[0], 32'd0);
      chk("tmo_polls",    sl_n[0], 32'd4);
      chk("tmo_err_held", {31'd0, err[0]}, 32'd1);

      // start during POLL and in FIN is ignored; start right after FIN is taken
      done_at[0] = 2; r5[0] = 32'h77; r6[0] = 32'h88;
      kick(0, 32'h1, 32'h2, 32'h3);
      wait_poll(0);
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      wait_done(0, 100, cyc);
      start[0] = 1'b1; sta = 32'hBEEF;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      chk("restart_w0", {28'd0, wr[0], addr[0]}, 32'h8);
      chk("restart_wd", wd[0], 32'hBEEF);
      wait_done(0, 100, cyc);
      @(posedge clk); #1;

      // done bit 3: status 0x1 keeps polling, 0x8 ends it
      nd_val[2] = 32'h1; dn_val[2] = 32'h8; done_at[2] = 2; r5[2] = 32'h55; r6[2] = 32'h66;
      kick(2, 32'h100, 32'h200, 32'h300);
      wait_done(2, 100, cyc);
      chk("db3_len", cyc, 32'd13);
      @(posedge clk); #1;
      chk("db3_res_status", rs[2],  32'h8);
      chk("db3_res_data",   rdd[2], 32'h66);
      chk("db3_polls",      sl_n[2], 32'd2);

      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
